// File: rtl/minterm_scanner_pkg.sv
// Shared types and constants for the minterm scanner: FSM state encoding and
// the default truth table loaded at reset.
package minterm_pkg;

   typedef enum logic [1:0] {
      IDLE,
      SCAN,
      DONE
   } state_t;

   // Bit m is f(m); set bits are minterms 7, 9, 10, 11, 13, 14.
   localparam logic [15:0] DEFAULT_INIT = 16'h6E80;

endpackage

// File: rtl/minterm_scanner_if.sv
// Handshake and truth-table bus of the minterm scanner; the producer side
// (scanner) uses the slave modport, the controlling side uses master.
interface minterm_scanner_if #(
   parameter int N = 4
);
   logic         start;
   logic         gray;
   logic         lut_we;
   logic [N-1:0] lut_addr;
   logic         lut_data;
   logic         out_ready;
   logic         out_valid;
   logic [N-1:0] minterm;
   logic         s;
   logic         busy;
   logic         done;
   logic [N:0]   ones_count;

   modport master (
      output start, gray, lut_we, lut_addr, lut_data, out_ready,
      input  out_valid, minterm, s, busy, done, ones_count
   );

   modport slave (
      input  start, gray, lut_we, lut_addr, lut_data, out_ready,
      output out_valid, minterm, s, busy, done, ones_count
   );
endinterface

// File: rtl/minterm_scanner_bin2gray.sv
// Pure combinational binary-to-reflected-Gray conversion.
module bin2gray #(
   parameter int N = 4
) (
   input  logic [N-1:0] bin_i,
   output logic [N-1:0] gray_o
);
   assign gray_o = bin_i ^ (bin_i >> 1);
endmodule

// File: rtl/minterm_scanner.sv
// Sweeps every input combination of an N-input boolean function held in a
// writable truth table, streaming (minterm, f(minterm)) over a valid/ready port.
module minterm_scanner
   import minterm_pkg::*;
#(
   parameter int                N    = 4,
   parameter logic [2**N-1:0]   INIT = (2**N)'(DEFAULT_INIT)
) (
   input logic              clk,
   input logic              reset,
   minterm_scanner_if.slave bus
);
   localparam int          M        = 2**N;
   localparam logic [N-1:0] IDX_ONE  = 1;
   localparam logic [N-1:0] IDX_LAST = '1;
   localparam logic [N:0]   CNT_ONE  = 1;

   state_t       state_q;
   logic [N-1:0] index_q;
   logic [N:0]   onesCount_q;
   logic         grayLatched_q;
   logic [M-1:0] table_q;
   logic         outValid_q;
   logic         busy_q;
   logic         done_q;

   logic [N-1:0] grayCode;
   logic [N-1:0] minterm_d;
   logic         sBit;
   logic         accept;

   bin2gray #(.N(N)) u_bin2gray (
      .bin_i  (index_q),
      .gray_o (grayCode)
   );

   assign minterm_d = grayLatched_q ? grayCode : index_q;
   assign sBit      = table_q[minterm_d];
   assign accept    = outValid_q & bus.out_ready;

   // State, table and handshake flags all move together; the table is only
   // writable outside SCAN so a running sweep always sees a stable function.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= IDLE;
         index_q       <= '0;
         onesCount_q   <= '0;
         grayLatched_q <= 1'b0;
         table_q       <= INIT;
         outValid_q    <= 1'b0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (bus.lut_we) table_q[bus.lut_addr] <= bus.lut_data;
               if (bus.start) begin
                  state_q       <= SCAN;
                  grayLatched_q <= bus.gray;
                  index_q       <= '0;
                  onesCount_q   <= '0;
                  outValid_q    <= 1'b1;
                  busy_q        <= 1'b1;
               end
            end
            SCAN: begin
               if (accept) begin
                  if (sBit) onesCount_q <= onesCount_q + CNT_ONE;
                  // The index parks on the last entry rather than wrapping.
                  if (index_q == IDX_LAST) begin
                     state_q    <= DONE;
                     outValid_q <= 1'b0;
                     busy_q     <= 1'b0;
                     done_q     <= 1'b1;
                  end else begin
                     index_q <= index_q + IDX_ONE;
                  end
               end
            end
            DONE: begin
               if (bus.lut_we) table_q[bus.lut_addr] <= bus.lut_data;
               state_q <= IDLE;
               done_q  <= 1'b0;
            end
            default: begin
               state_q    <= IDLE;
               outValid_q <= 1'b0;
               busy_q     <= 1'b0;
               done_q     <= 1'b0;
            end
         endcase
      end
   end

   assign bus.out_valid  = outValid_q;
   assign bus.busy       = busy_q;
   assign bus.done       = done_q;
   assign bus.minterm    = minterm_d;
   assign bus.s          = sBit;
   assign bus.ones_count = onesCount_q;

endmodule

// File: tb/tb_minterm_scanner.sv
// Self-checking bench for minterm_scanner: directed sweeps plus randomized
// stall/table patterns compared against a truth-table array model.
module tb_minterm_scanner;
   import minterm_pkg::*;

   localparam int N = 4;
   localparam int M = 16;

   logic clk = 1'b0;
   logic reset;
   int   checks   = 0;
   int   failures = 0;
   bit   model [M];
   int   cyc;
   int   ones;

   always #5 clk = ~clk;

   minterm_scanner_if #(.N(N)) bus ();

   minterm_scanner #(.N(N)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic applyStimulus(input bit st, input bit g, input bit we,
                                input int addr, input bit data, input bit rdy);
      bus.start     = st;
      bus.gray      = g;
      bus.lut_we    = we;
      bus.lut_addr  = 4'(addr);
      bus.lut_data  = data;
      bus.out_ready = rdy;
   endtask

   task automatic loadInitModel();
      logic [15:0] initTbl;
      initTbl = DEFAULT_INIT;
      for (int i = 0; i < M; i++) model[i] = initTbl[i];
   endtask

   task automatic writeLut(input int addr, input bit data);
      applyStimulus(0, 0, 1, addr, data, 0);
      step();
      model[addr] = data;
      applyStimulus(0, 0, 0, 0, 0, 0);
   endtask

   task automatic checkIdle(input string tag, input int expOnes);
      checkOutput({tag, "_valid"}, 32'(bus.out_valid), 0);
      checkOutput({tag, "_busy"}, 32'(bus.busy), 0);
      checkOutput({tag, "_done"}, 32'(bus.done), 0);
      checkOutput({tag, "_ones"}, 32'(bus.ones_count), 32'(expOnes));
   endtask

   // stallMode: 0 always ready, 1 random ready, 2 three stalls at minterm 5.
   task automatic sweep(input bit g, input int stallMode, input bit noise, input int resetAt,
                        input int wAddr, input bit wData, output int cycles, output int onesOut);
      int  k, m, stalls, expOnes;
      bit  rdy, aborted;
      applyStimulus(1, g, wAddr >= 0, (wAddr >= 0) ? wAddr : 0, wData, 1);
      if (wAddr >= 0) model[wAddr] = wData;
      step();
      k = 0; expOnes = 0; cycles = 0; stalls = 0; aborted = 0;
      while (k < M && cycles < 400 && !aborted) begin
         m = g ? (k ^ (k >> 1)) : k;
         case (stallMode)
            1:       rdy = 1'($urandom_range(0, 1));
            2:       rdy = !(m == 5 && stalls < 3);
            default: rdy = 1'b1;
         endcase
         if (!rdy) stalls++;
         if (noise)
            applyStimulus(1'($urandom), 1'($urandom), 1'($urandom), int'($urandom_range(0, M-1)),
                          1'($urandom), rdy);
         else
            applyStimulus(0, 0, 0, 0, 0, rdy);
         checkOutput("scanValid", 32'(bus.out_valid), 1);
         checkOutput("scanBusy", 32'(bus.busy), 1);
         checkOutput("scanDone", 32'(bus.done), 0);
         checkOutput("minterm", 32'(bus.minterm), 32'(m));
         checkOutput("sValue", 32'(bus.s), 32'(model[m]));
         checkOutput("runningOnes", 32'(bus.ones_count), 32'(expOnes));
         if (resetAt == k) begin
            reset = 1'b1;
            aborted = 1'b1;
         end
         step();
         reset = 1'b0;
         cycles++;
         if (rdy && !aborted) begin
            if (model[m]) expOnes++;
            k++;
         end
      end
      applyStimulus(0, 0, 0, 0, 0, 0);
      if (aborted) begin
         loadInitModel();
         expOnes = 0;
         checkIdle("abort", 0);
         checkOutput("abortMinterm", 32'(bus.minterm), 0);
         for (int i = 0; i < 3; i++) begin
            step();
            checkOutput("abortNoDone", 32'(bus.done), 0);
         end
      end else begin
         checkOutput("sweepLength", 32'(k), 32'(M));
         checkOutput("donePulse", 32'(bus.done), 1);
         checkOutput("doneValid", 32'(bus.out_valid), 0);
         checkOutput("doneBusy", 32'(bus.busy), 0);
         checkOutput("doneOnes", 32'(bus.ones_count), 32'(expOnes));
         step();
         checkIdle("afterDone", expOnes);
      end
      onesOut = expOnes;
   endtask

   initial begin
      reset = 1'b1;
      applyStimulus(1, 1, 1, 3, 1, 1);
      loadInitModel();
      step();
      step();
      reset = 1'b0;
      applyStimulus(0, 0, 0, 0, 0, 0);
      checkIdle("reset", 0);
      checkOutput("resetMinterm", 32'(bus.minterm), 0);

      sweep(0, 0, 0, -1, -1, 0, cyc, ones);
      checkOutput("binCycles", 32'(cyc), 16);
      checkOutput("binOnes", 32'(ones), 6);

      sweep(1, 0, 0, -1, -1, 0, cyc, ones);
      checkOutput("grayOnes", 32'(bus.ones_count), 6);

      sweep(0, 2, 0, -1, -1, 0, cyc, ones);
      checkOutput("stallCycles", 32'(cyc), 19);
      checkOutput("stallOnes", 32'(bus.ones_count), 6);

      writeLut(7, 0);
      writeLut(9, 0);
      sweep(0, 0, 0, -1, -1, 0, cyc, ones);
      checkOutput("editedOnes", 32'(bus.ones_count), 4);
      writeLut(7, 1);
      writeLut(9, 1);

      sweep(1, 1, 1, -1, -1, 0, cyc, ones);
      checkOutput("noiseOnes", 32'(bus.ones_count), 6);

      sweep(0, 0, 0, -1, 0, 1, cyc, ones);
      checkOutput("startWriteOnes", 32'(bus.ones_count), 7);
      writeLut(0, 0);

      writeLut(2, 1);
      sweep(0, 1, 0, 8, -1, 0, cyc, ones);
      sweep(0, 0, 0, -1, -1, 0, cyc, ones);
      checkOutput("afterResetOnes", 32'(bus.ones_count), 6);

      for (int r = 0; r < 8; r++) begin
         for (int w = 0; w < 3; w++) writeLut(int'($urandom_range(0, M-1)), 1'($urandom));
         sweep(1'($urandom), 1, 1'($urandom), -1, -1, 0, cyc, ones);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/minterm_scanner.md
MINTERM_SCANNER -- requirements
Module: minterm_scanner

Interface
REQ-001 Parameters SHALL be:
- N, default 4: number of function inputs; legal range 2..8.
- INIT, default 16'h6E80 (width 2^N): reset truth table; bit m is f(m), with input a = MSB of m.

REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk  in  1  single clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high.
- start  in  1  request a full sweep; accepted only in IDLE.
- gray  in  1  sweep order for the accepted sweep: 0 = binary, 1 = Gray code.
- lut_we  in  1  truth-table write enable.
- lut_addr  in  N  truth-table entry to write.
- lut_data  in  1  value written to that entry.
- out_ready  in  1  consumer accepts the current output.
- out_valid  out  1  minterm and s are valid.
- minterm  out  N  current input combination.
- s  out  1  f(minterm) from the truth table.
- busy  out  1  high in SCAN.
- done  out  1  one-cycle pulse after the last minterm is accepted.
- ones_count  out  N+1  number of accepted minterms with s = 1.

Function
REQ-003 The FSM SHALL have exactly three states: IDLE, SCAN and DONE.
REQ-004 Transitions SHALL be:
- IDLE→SCAN on start = 1.
- SCAN→DONE when the output with index 2^N-1 is accepted (out_valid & out_ready).
- DONE→IDLE unconditionally after one cycle.
REQ-005 On accepting start, the block SHALL latch gray, clear the index and clear ones_count. The first out_valid SHALL appear in the next cycle, with index 0.
REQ-006 The output minterm SHALL be the index in binary order, or index ^ (index >> 1) when the latched gray = 1.
REQ-007 s SHALL equal table[minterm] combinationally in the same cycle as minterm.
REQ-008 While out_valid = 1 and out_ready = 0, minterm, s and the index SHALL hold unchanged.
REQ-009 The index SHALL advance by one per accepted output, with no wrap-around inside a sweep.
REQ-010 On each accepted output with s = 1, ones_count SHALL increment. Maximum value is 2^N, with no overflow.
REQ-011 ones_count SHALL hold its value in DONE and IDLE until the next accepted start.
REQ-012 out_valid and busy SHALL be 1 only in SCAN. done SHALL be 1 only in DONE.
REQ-013 A table write with lut_we = 1 SHALL update the entry at the clock edge, in IDLE or DONE only.
REQ-014 lut_we in SCAN SHALL be ignored, and the table SHALL be unchanged.
REQ-015 When start and lut_we are both 1 in IDLE, the write SHALL take effect, and the sweep SHALL use the updated table.
REQ-016 start in SCAN or DONE SHALL be ignored. It SHALL NOT be queued.
REQ-017 The gray input SHALL be sampled only when start is accepted.

Reset
REQ-018 With reset = 1 at a rising edge, the block SHALL set:
- state = IDLE, index = 0, ones_count = 0, latched gray = 0;
- table = INIT;
- out_valid = 0, busy = 0, done = 0, minterm = 0.
REQ-019 Reset SHALL override all other inputs, including mid-SCAN. No done pulse SHALL follow an aborted sweep.

Structure
REQ-020 Package minterm_pkg SHALL hold the state enum (IDLE, SCAN, DONE) and the default INIT constant 16'h6E80.
REQ-021 The binary-to-Gray conversion SHALL be a sub-module named bin2gray, parameterised by N.
REQ-022 The truth table SHALL be a 2^N-bit register, not inferred RAM.

Verification
REQ-023 Reset, then start with gray = 0 and out_ready = 1:
- minterm steps 0..15 on consecutive cycles;
- s = 1 only at minterms 7, 9, 10, 11, 13, 14;
- done pulses once; ones_count = 6.
REQ-024 Start with gray = 1:
- minterm order 0,1,3,2,6,7,5,4,12,13,15,14,10,11,9,8;
- ones_count = 6.
REQ-025 Hold out_ready = 0 for 3 cycles at minterm 5:
- minterm and s stay constant;
- the sweep takes 19 cycles;
- ones_count = 6.
REQ-026 Write entries 7 and 9 to 0 in IDLE, then sweep: ones_count = 4.
REQ-027 Assert lut_we and start during SCAN: table and sweep are unaffected; ones_count = 6; exactly one done pulse.
REQ-028 Assert reset at minterm 8:
- next cycle is IDLE, with ones_count = 0 and table = 16'h6E80;
- no done pulse.
